// File: rtl/threshold_frame_ctrl.sv
// Two-pass frame controller: pass 1 folds a frame into its maximum, pass 2 binarises against max >> 1.
// Optional build macro THRCTRL_MAXOUT_EN emits the frame maximum as a header token before pass 2.
module threshold_frame_ctrl #(
   parameter int unsigned FRAME_PIXELS = 262144,
   parameter int unsigned PIX_W        = 8,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   input  logic [PIX_W-1:0] In1_DATA,
   input  logic             In1_SEND,
   output logic             In1_ACK,
   input  logic [15:0]      In1_COUNT,
   output logic [PIX_W-1:0] Out1_DATA,
   output logic             Out1_SEND,
   input  logic             Out1_ACK,
   input  logic             Out1_RDY,
   output logic [15:0]      Out1_COUNT,
   output logic [PIX_W-1:0] MAX_VALUE
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FOLD,
      S_LATCH,
`ifdef THRCTRL_MAXOUT_EN
      S_HDR,
`endif
      S_APPLY,
      S_FIN
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [PIX_W-1:0] max_r, max_nxt;
   logic [PIX_W-1:0] thr, thr_nxt;
   logic [PIX_W-1:0] max_value_nxt;

   // Count and ACK inputs are part of the shared actor interface but carry no information here
   logic unused_ok;
   assign unused_ok = ^{In1_COUNT, Out1_ACK};

   assign Out1_COUNT = 16'h1;
   assign BUSY       = (state != S_IDLE);
   assign DONE       = (state == S_FIN);

   // State and datapath registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= S_IDLE;
         count     <= '0;
         max_r     <= '0;
         thr       <= '0;
         MAX_VALUE <= '0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         max_r     <= max_nxt;
         thr       <= thr_nxt;
         MAX_VALUE <= max_value_nxt;
      end
   end

   // Next-state, datapath updates and handshake outputs
   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      max_nxt       = max_r;
      thr_nxt       = thr;
      max_value_nxt = MAX_VALUE;
      In1_ACK       = 1'b0;
      Out1_SEND     = 1'b0;
      Out1_DATA     = '0;

      case (state)
         S_IDLE: begin
            if (START) begin
               state_nxt = S_FOLD;
               count_nxt = '0;
               max_nxt   = '0;
            end
         end
         S_FOLD: begin
            In1_ACK = In1_SEND;
            if (In1_SEND) begin
               if (In1_DATA > max_r) max_nxt = In1_DATA;
               count_nxt = count + CNT_W'(1);
               if (count == LAST_IDX) state_nxt = S_LATCH;
            end
         end
         S_LATCH: begin
            thr_nxt       = max_r >> 1;
            max_value_nxt = max_r;
            count_nxt     = '0;
`ifdef THRCTRL_MAXOUT_EN
            state_nxt     = S_HDR;
`else
            state_nxt     = S_APPLY;
`endif
         end
`ifdef THRCTRL_MAXOUT_EN
         S_HDR: begin
            Out1_SEND = Out1_RDY;
            Out1_DATA = max_r;
            if (Out1_RDY) state_nxt = S_APPLY;
         end
`endif
         S_APPLY: begin
            // Both sides move together so no token is consumed without being emitted
            if (In1_SEND && Out1_RDY) begin
               In1_ACK   = 1'b1;
               Out1_SEND = 1'b1;
               Out1_DATA = (In1_DATA > thr) ? '1 : '0;
               count_nxt = count + CNT_W'(1);
               if (count == LAST_IDX) state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_threshold_frame_ctrl.sv
// Self-checking bench for threshold_frame_ctrl with a frame-level reference model.
// Honours THRCTRL_MAXOUT_EN when the design is built with it.
module tb_threshold_frame_ctrl;

   localparam int unsigned NP = 4;
`ifdef THRCTRL_MAXOUT_EN
   localparam bit HDR     = 1'b1;
   localparam int EXP_LAT = 2 * NP + 4;
`else
   localparam bit HDR     = 1'b0;
   localparam int EXP_LAT = 2 * NP + 3;
`endif

   logic        CLK = 1'b0;
   logic        RESET, START;
   logic        BUSY, DONE;
   logic [7:0]  In1_DATA;
   logic        In1_SEND, In1_ACK;
   logic [15:0] In1_COUNT;
   logic [7:0]  Out1_DATA;
   logic        Out1_SEND, Out1_ACK, Out1_RDY;
   logic [15:0] Out1_COUNT;
   logic [7:0]  MAX_VALUE;

   threshold_frame_ctrl #(.FRAME_PIXELS(NP), .PIX_W(8), .CNT_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
      .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_ACK(In1_ACK), .In1_COUNT(In1_COUNT),
      .Out1_DATA(Out1_DATA), .Out1_SEND(Out1_SEND), .Out1_ACK(Out1_ACK), .Out1_RDY(Out1_RDY),
      .Out1_COUNT(Out1_COUNT), .MAX_VALUE(MAX_VALUE)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   logic [7:0] src [2*NP];   // pass 1 pixels then pass 2 pixels
   logic [7:0] got_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] exp_max;
   int done_cnt, lat, ack_err, busy_after;
   bit timed_out;

   // Reference: frame max, threshold = max/2, header token optional
   task automatic build_expected();
      int m = 0;
      exp_q.delete();
      for (int i = 0; i < NP; i++) if (int'(src[i]) > m) m = int'(src[i]);
      exp_max = 8'(m);
      if (HDR) exp_q.push_back(exp_max);
      for (int i = 0; i < NP; i++)
         exp_q.push_back((int'(src[NP+i]) > m / 2) ? 8'hFF : 8'h00);
   endtask

   // rdy_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random
   task automatic run_frame(input int rdy_mode, input bit send_rnd,
                            input bit start_fold, input bit start_fin);
      int  i1 = 0;
      bit  fin = 1'b0;
      got_q.delete();
      done_cnt = 0; lat = 0; ack_err = 0; busy_after = 0; timed_out = 1'b0;
      for (int k = 0; k < 400 && !fin; k++) begin
         @(posedge CLK); #1;
         START    = (k == 0) || (start_fold && k == 3);
         In1_SEND = (i1 < 2*NP) && (send_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         In1_DATA = (i1 < 2*NP) ? src[i1] : 8'($urandom);
         case (rdy_mode)
            0:       Out1_RDY = 1'b1;
            1:       Out1_RDY = (k % 3 == 0);
            default: Out1_RDY = 1'($urandom_range(0, 1));
         endcase
         @(negedge CLK);
         if (i1 < NP) begin
            if (Out1_SEND || (k > 0 && In1_ACK !== In1_SEND)) ack_err++;
         end else if (!(HDR && got_q.size() == 0)) begin
            if (In1_ACK !== Out1_SEND) ack_err++;
         end
         if (In1_ACK) i1++;
         if (Out1_SEND) got_q.push_back(Out1_DATA);
         if (DONE) begin
            done_cnt++;
            lat = k + 1;
            fin = 1'b1;
            if (start_fin) START = 1'b1;
         end
      end
      if (!fin) timed_out = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0; In1_SEND = 1'b0; Out1_RDY = 1'b0;
      repeat (12) begin
         @(negedge CLK);
         if (DONE) done_cnt++;
         if (BUSY) busy_after++;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; In1_SEND = 1'b1; Out1_RDY = 1'b1;
      In1_DATA = 8'hFF; In1_COUNT = 16'h0; Out1_ACK = 1'b0;
      repeat (2) @(negedge CLK);
      tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", BUSY); end
      tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", DONE); end
      tests++; if (In1_ACK !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", In1_ACK); end
      tests++; if (Out1_SEND !== 1'b0) begin fails++; $display("FAIL reset_send got %b want 0", Out1_SEND); end
      tests++; if (Out1_DATA !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", Out1_DATA); end
      tests++; if (MAX_VALUE !== 8'h00) begin fails++; $display("FAIL reset_max got %h want 00", MAX_VALUE); end
      tests++; if (Out1_COUNT !== 16'h1) begin fails++; $display("FAIL reset_count got %h want 0001", Out1_COUNT); end
      @(posedge CLK); #1; RESET = 1'b0; In1_SEND = 1'b0;
   endtask

   task automatic test_basic();
      src = '{8'd10, 8'd200, 8'd7, 8'd90, 8'd10, 8'd200, 8'd7, 8'd90};
      build_expected();
      run_frame(0, 1'b0, 1'b0, 1'b0);
      tests++; if (timed_out) begin fails++; $display("FAIL basic_timeout got no DONE want DONE"); end
      tests++; if (MAX_VALUE !== 8'd200) begin fails++; $display("FAIL basic_max got %0d want 200", MAX_VALUE); end
      tests++; if (lat != EXP_LAT) begin fails++; $display("FAIL basic_latency got %0d want %0d", lat, EXP_LAT); end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL basic_ntok got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_tok%0d got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_unsigned();
      src = '{8'd255, 8'd128, 8'd0, 8'd0, 8'd128, 8'd129, 8'd127, 8'd255};
      build_expected();
      run_frame(0, 1'b0, 1'b0, 1'b0);
      tests++; if (MAX_VALUE !== 8'd255) begin fails++; $display("FAIL uns_max got %0d want 255", MAX_VALUE); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL uns_ntok got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL uns_tok%0d got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_rdy_toggle();
      src = '{8'd10, 8'd200, 8'd7, 8'd90, 8'd150, 8'd100, 8'd101, 8'd3};
      build_expected();
      run_frame(1, 1'b0, 1'b0, 1'b0);
      tests++; if (ack_err != 0) begin fails++; $display("FAIL rdy_ack_mirror got %0d errors want 0", ack_err); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rdy_ntok got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rdy_tok%0d got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_midframe();
      @(posedge CLK); #1; START = 1'b1; In1_SEND = 1'b1; In1_DATA = 8'd50; Out1_RDY = 1'b1;
      @(posedge CLK); #1; START = 1'b0;
      repeat (2) @(posedge CLK);
      #1; RESET = 1'b1;
      @(negedge CLK);
      tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", BUSY); end
      tests++; if (In1_ACK !== 1'b0) begin fails++; $display("FAIL midrst_ack got %b want 0", In1_ACK); end
      tests++; if (MAX_VALUE !== 8'h00) begin fails++; $display("FAIL midrst_max got %h want 00", MAX_VALUE); end
      tests++; if (DONE !== 1'b0 || Out1_SEND !== 1'b0 || Out1_DATA !== 8'h00) begin
         fails++; $display("FAIL midrst_out got done=%b send=%b data=%h want 0 0 00", DONE, Out1_SEND, Out1_DATA);
      end
      @(posedge CLK); #1; RESET = 1'b0; In1_SEND = 1'b0;
      src = '{8'd20, 8'd60, 8'd61, 8'd5, 8'd31, 8'd30, 8'd29, 8'd61};
      build_expected();
      run_frame(0, 1'b0, 1'b0, 1'b0);
      tests++; if (MAX_VALUE !== exp_max) begin fails++; $display("FAIL midrst_newmax got %0d want %0d", MAX_VALUE, exp_max); end
      tests++; if (got_q != exp_q || done_cnt != 1) begin
         fails++; $display("FAIL midrst_frame got %0d tokens done=%0d want %0d tokens done=1", got_q.size(), done_cnt, exp_q.size());
      end
   endtask

   task automatic test_start_ignored();
      src = '{8'd9, 8'd40, 8'd33, 8'd12, 8'd21, 8'd20, 8'd19, 8'd40};
      build_expected();
      run_frame(0, 1'b0, 1'b1, 1'b1);
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL startign_done got %0d want 1", done_cnt); end
      tests++; if (busy_after != 0) begin fails++; $display("FAIL startign_busy got %0d busy cycles want 0", busy_after); end
      tests++; if (got_q != exp_q) begin fails++; $display("FAIL startign_tokens got %0d tokens want %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < NP; i++) begin
            src[i]      = 8'($urandom);
            src[NP + i] = src[i];
         end
         if (f % 2 == 1) for (int i = 0; i < NP; i++) src[NP + i] = 8'($urandom);
         build_expected();
         run_frame(2, 1'b1, 1'b0, 1'b0);
         tests++; if (timed_out || done_cnt != 1) begin fails++; $display("FAIL rnd%0d_done got %0d timeout=%b want 1", f, done_cnt, timed_out); end
         tests++; if (MAX_VALUE !== exp_max) begin fails++; $display("FAIL rnd%0d_max got %0d want %0d", f, MAX_VALUE, exp_max); end
         tests++; if (ack_err != 0) begin fails++; $display("FAIL rnd%0d_handshake got %0d errors want 0", f, ack_err); end
         tests++; if (got_q != exp_q) begin fails++; $display("FAIL rnd%0d_tokens got %0d tokens want %0d", f, got_q.size(), exp_q.size()); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_unsigned();
      test_rdy_toggle();
      test_reset_midframe();
      test_start_ignored();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
